fft_input_buffer: RTL and testbench

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

---
 rtl/fft_input_buffer.sv | 168 ++++++++++++++++
 tb/tb_fft_input_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fft_input_buffer.sv
// fft_input_buffer
//   Stage-1 feeder for a 16-point radix-2 DIF FFT. Real time-domain samples
//   are converted to Q16.16 and collected into one of two 16-entry banks.
//   When a bank fills, the banks swap. The full bank is then drained as
//   eight butterfly operand pairs, x[k] and x[k+8], one pair per cycle.
//   Each pair is issued together with its twiddle W16^k.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_data    input sample stream, Q(IN_W-IN_FRAC).IN_FRAC signed
//   valid                operand pair + twiddle valid
//   real_b, imag_b       upper-half operand x[k], Q16.16
//   real_a, imag_a       lower-half operand x[k+8], Q16.16
//   Real_coff, Imag_coff twiddle W16^k, Q16.16
//   pair_idx             k of the current pair (0..7)
//   frame_last           high with valid on the k=7 pair
module fft_input_buffer #(
  parameter int IN_W    = 16,
  parameter int IN_FRAC = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   valid,
  output logic signed [31:0]     real_b,
  output logic signed [31:0]     imag_b,
  output logic signed [31:0]     real_a,
  output logic signed [31:0]     imag_a,
  output logic signed [31:0]     Real_coff,
  output logic signed [31:0]     Imag_coff,
  output logic [2:0]             pair_idx,
  output logic                   frame_last
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [2:0]         cnt, cnt_nxt;
  logic [3:0]         wr_cnt;
  logic               fill_sel;
  logic               drain_req;
  logic               issue;
  logic [2:0]         issue_k;
  logic               rd_sel;
  logic signed [31:0] sample_ext, sample_q;
  logic [31:0]        bank [2][16];

  // Sign-extend, then align the binary point to bit 16. No rounding or saturation.
  assign sample_ext = 32'(in_data);
  assign sample_q   = sample_ext <<< (16 - IN_FRAC);

  assign drain_req  = in_valid && (wr_cnt == 4'd15);

  function automatic logic signed [31:0] tw_re(input logic [2:0] k);
    case (k)
      3'd0: tw_re =  32'sd65536;
      3'd1: tw_re =  32'sd60547;
      3'd2: tw_re =  32'sd46341;
      3'd3: tw_re =  32'sd25080;
      3'd4: tw_re =  32'sd0;
      3'd5: tw_re = -32'sd25080;
      3'd6: tw_re = -32'sd46341;
      default: tw_re = -32'sd60547;
    endcase
  endfunction

  function automatic logic signed [31:0] tw_im(input logic [2:0] k);
    case (k)
      3'd0: tw_im =  32'sd0;
      3'd1: tw_im = -32'sd25080;
      3'd2: tw_im = -32'sd46341;
      3'd3: tw_im = -32'sd60547;
      3'd4: tw_im = -32'sd65536;
      3'd5: tw_im = -32'sd60547;
      3'd6: tw_im = -32'sd46341;
      default: tw_im = -32'sd25080;
    endcase
  endfunction

  // Bank storage needs no reset. A write during reset is harmless because
  // wr_cnt is held at 0 and the frame restarts at entry 0.
  always_ff @(posedge clk) begin
    if (in_valid) bank[fill_sel][wr_cnt] <= sample_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt   <= '0;
      fill_sel <= 1'b0;
    end else if (in_valid) begin
      wr_cnt <= wr_cnt + 4'd1;
      if (wr_cnt == 4'd15) fill_sel <= ~fill_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The k=0 pair is issued at the edge that accepts the 16th sample.
  // This gives valid a one-cycle latency with registered outputs.
  // At that edge the bank swap has not yet happened, so k=0 is read from
  // the current fill bank. Entries 0 and 8 are already stable there.
  // The pairs k=1..7 are read from the bank that was just swapped out.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    issue_k   = cnt;
    rd_sel    = ~fill_sel;
    case (state)
      IDLE: begin
        if (drain_req) begin
          issue     = 1'b1;
          issue_k   = 3'd0;
          rd_sel    = fill_sel;
          state_nxt = DRAIN;
          cnt_nxt   = 3'd1;
        end
      end
      DRAIN: begin
        issue = 1'b1;
        if (cnt == 3'd7) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data outputs only load on an issue, so they hold while valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      frame_last <= 1'b0;
      pair_idx   <= '0;
      real_b     <= '0;
      imag_b     <= '0;
      real_a     <= '0;
      imag_a     <= '0;
      Real_coff  <= '0;
      Imag_coff  <= '0;
    end else begin
      valid      <= issue;
      frame_last <= issue && (issue_k == 3'd7);
      if (issue) begin
        pair_idx  <= issue_k;
        real_b    <= bank[rd_sel][{1'b0, issue_k}];
        real_a    <= bank[rd_sel][{1'b1, issue_k}];
        imag_b    <= '0;
        imag_a    <= '0;
        Real_coff <= tw_re(issue_k);
        Imag_coff <= tw_im(issue_k);
      end
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer.
// The reference model collects converted samples into a frame. On the
// 16th accepted sample it queues the eight expected pairs. One queued
// pair is expected per following cycle. When the queue is empty, valid
// is expected low and the data outputs are expected to hold.
module tb_fft_input_buffer;
  localparam int IN_W    = 16;
  localparam int IN_FRAC = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic signed [IN_W-1:0] in_data;
  logic                   valid;
  logic signed [31:0]     real_b, imag_b, real_a, imag_a, Real_coff, Imag_coff;
  logic [2:0]             pair_idx;
  logic                   frame_last;

  fft_input_buffer #(.IN_W(IN_W), .IN_FRAC(IN_FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .valid(valid), .real_b(real_b), .imag_b(imag_b), .real_a(real_a),
    .imag_a(imag_a), .Real_coff(Real_coff), .Imag_coff(Imag_coff),
    .pair_idx(pair_idx), .frame_last(frame_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  k;
    logic        fl;
    logic [31:0] b, a, wr, wi;
  } exp_t;

  int vecs = 0;
  int errs = 0;
  int tw_re_t [8] = '{65536, 60547, 46341, 25080, 0, -25080, -46341, -60547};
  int tw_im_t [8] = '{0, -25080, -46341, -60547, -65536, -60547, -46341, -25080};

  logic [31:0] fr [16];
  int          n = 0;
  exp_t        pend [$];
  exp_t        last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] conv(input logic [IN_W-1:0] d);
    int s;
    s = int'($signed(d));
    return 32'(s * (1 << (16 - IN_FRAC)));
  endfunction

  task automatic check_outputs(input exp_t e);
    chk("valid",      32'(valid),      32'(e.v));
    chk("frame_last", 32'(frame_last), 32'(e.fl));
    chk("pair_idx",   32'(pair_idx),   32'(e.k));
    chk("real_b",     real_b,          e.b);
    chk("real_a",     real_a,          e.a);
    chk("imag_b",     imag_b,          32'd0);
    chk("imag_a",     imag_a,          32'd0);
    chk("Real_coff",  Real_coff,       e.wr);
    chk("Imag_coff",  Imag_coff,       e.wi);
  endtask

  // One clock cycle: drive the inputs, update the model, clock, then check.
  task automatic step(input logic v, input logic [IN_W-1:0] d);
    exp_t e;
    in_valid = v;
    in_data  = d;
    if (v) begin
      fr[n] = conv(d);
      n++;
      if (n == 16) begin
        for (int k = 0; k < 8; k++) begin
          e.v  = 1'b1;
          e.k  = 3'(k);
          e.fl = (k == 7);
          e.b  = fr[k];
          e.a  = fr[k + 8];
          e.wr = 32'(tw_re_t[k]);
          e.wi = 32'(tw_im_t[k]);
          pend.push_back(e);
        end
        n = 0;
      end
    end
    @(posedge clk);
    #1;
    if (pend.size() > 0) begin
      e    = pend.pop_front();
      last = e;
    end else begin
      e    = last;
      e.v  = 1'b0;
      e.fl = 1'b0;
    end
    check_outputs(e);
  endtask

  // Raise reset mid-cycle, check the asynchronous clear, then release it after one edge.
  task automatic do_reset();
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    last = '{1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_outputs(last);
    pend.delete();
    n = 0;
    @(posedge clk);
    #1;
    check_outputs(last);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    last     = '{1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0};
    #3;
    check_outputs(last);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, '0);

    // Ramp frame x[n] = n*1.0, with explicit spot checks on the known values.
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i * 256));
    chk("ramp_k0_real_b", real_b, 32'h0000_0000);
    chk("ramp_k0_real_a", real_a, 32'h0008_0000);
    for (int i = 0; i < 7; i++) step(1'b0, '0);
    chk("ramp_k7_real_b", real_b, 32'h0007_0000);
    chk("ramp_k7_real_a", real_a, 32'h000F_0000);
    chk("ramp_k7_coff",   Real_coff, 32'(-60547));
    chk("ramp_k7_last",   32'(frame_last), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0);

    // Negative samples: -1.0 converts to 0xFFFF0000.
    for (int i = 0; i < 16; i++) step(1'b1, 16'hFF00);
    chk("neg_real_b", real_b, 32'hFFFF_0000);
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    // Two random frames back to back with continuous in_valid, then idle.
    for (int i = 0; i < 32; i++) step(1'b1, 16'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    // Alternate in_valid 1,0 across a whole frame.
    for (int i = 0; i < 32; i++) step(1'((i % 2) == 0), 16'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    // Random in_valid gaps across several frames.
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 2) != 0), 16'($urandom));
    for (int i = 0; i < 12; i++) step(1'b0, '0);

    // Reset in the middle of a fill discards the partial frame.
    for (int i = 0; i < 7; i++) step(1'b1, 16'($urandom));
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    // Reset while the k=3 pair is on the outputs aborts the drain.
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    chk("abort_at_k3", 32'(pair_idx), 32'd3);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    // Continuous stream over three frames, including the 8-on/8-off cadence.
    for (int i = 0; i < 48; i++) step(1'b1, 16'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
